// File: rtl/action_scheduler.sv
// action_scheduler: buffers player actions, generates gravity and the game countdown,
// and issues one datapath command at a time over a valid/done handshake.
module action_scheduler #(
    parameter int QSIZE     = 16,
    parameter int DOWN_TICK = 25_000_000,
    parameter int SEC_TICK  = 25_000_000,
    parameter int COUNT_SEC = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       btn_valid,
    input  logic [7:0] btn_op,
    output logic       cmd_valid,
    output logic [7:0] cmd_op,
    input  logic       cmd_done,
    input  logic       landed,
    input  logic       game_over,
    output logic [6:0] sec_left,
    output logic       running,
    output logic       overflow,
    output logic [1:0] dbg_state
);

    localparam logic [7:0] OP_NONE       = 8'd0;
    localparam logic [7:0] OP_INIT       = 8'd1;
    localparam logic [7:0] OP_GEN        = 8'd2;
    localparam logic [7:0] OP_LEFT       = 8'd3;
    localparam logic [7:0] OP_RIGHT      = 8'd4;
    localparam logic [7:0] OP_DOWN       = 8'd5;
    localparam logic [7:0] OP_DROP       = 8'd6;
    localparam logic [7:0] OP_HOLD       = 8'd7;
    localparam logic [7:0] OP_ROTATE     = 8'd8;
    localparam logic [7:0] OP_ROTATE_REV = 8'd9;
    localparam logic [7:0] OP_END        = 8'd10;

    localparam int PW = (QSIZE > 1) ? $clog2(QSIZE) : 1;
    localparam int CW = $clog2(QSIZE + 1);
    localparam int GW = (DOWN_TICK > 1) ? $clog2(DOWN_TICK) : 1;
    localparam int SW = (SEC_TICK > 1) ? $clog2(SEC_TICK) : 1;

    localparam logic [PW-1:0] PTR_LAST  = PW'(QSIZE - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(QSIZE);
    localparam logic [GW-1:0] GRAV_LAST = GW'(DOWN_TICK - 1);
    localparam logic [SW-1:0] SEC_LAST  = SW'(SEC_TICK - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_SELECT = 2'd2,
        S_OVER   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           cmd_valid_q, cmd_valid_d;
    logic [7:0]     cmd_op_q, cmd_op_d;
    logic           need_gen_q, need_gen_d;
    logic           grav_pending_q;
    logic [GW-1:0]  grav_cnt_q;
    logic [SW-1:0]  sec_cnt_q;
    logic [6:0]     sec_left_q;
    logic           running_q;
    logic           overflow_q;
    logic [7:0]     fifo_mem_q [QSIZE];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q;

    logic pop, pend_clr, start_game, stop_game;
    logic legal_op, push_req, push, fifo_full, fifo_empty;
    logic grav_wrap, sec_wrap, end_cond, done_seen;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        legal_op = 1'b0;
        case (btn_op)
            OP_LEFT, OP_RIGHT, OP_DOWN, OP_DROP,
            OP_HOLD, OP_ROTATE, OP_ROTATE_REV: legal_op = 1'b1;
            default:                           legal_op = 1'b0;
        endcase
    end

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);
    assign grav_wrap  = running_q && (grav_cnt_q == GRAV_LAST);
    assign sec_wrap   = running_q && (sec_cnt_q == SEC_LAST);
    assign end_cond   = running_q && (game_over || (sec_left_q == 7'd0));
    assign done_seen  = cmd_valid_q && cmd_done;

    // Handshake: cmd_valid rises together with cmd_op and both hold until cmd_done
    // is seen while cmd_valid is high; that cycle retires the command (INIT chains
    // straight into GEN). cmd_done while cmd_valid is low has no effect.
    always_comb begin
        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        cmd_op_d    = cmd_op_q;
        need_gen_d  = need_gen_q;
        pop         = 1'b0;
        pend_clr    = 1'b0;
        start_game  = 1'b0;
        stop_game   = 1'b0;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    start_game  = 1'b1;
                    need_gen_d  = 1'b0;
                    cmd_valid_d = 1'b1;
                    cmd_op_d    = OP_INIT;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (done_seen) begin
                    if (cmd_op_q == OP_INIT) begin
                        cmd_op_d = OP_GEN;
                    end else if (cmd_op_q == OP_END) begin
                        cmd_valid_d = 1'b0;
                        stop_game   = 1'b1;
                        state_d     = S_OVER;
                    end else begin
                        cmd_valid_d = 1'b0;
                        need_gen_d  = landed;
                        state_d     = S_SELECT;
                    end
                end
            end
            S_SELECT: begin
                state_d     = S_ISSUE;
                cmd_valid_d = 1'b1;
                if (end_cond) begin
                    cmd_op_d = OP_END;
                end else if (need_gen_q) begin
                    cmd_op_d   = OP_GEN;
                    need_gen_d = 1'b0;
                end else if (grav_pending_q) begin
                    cmd_op_d = OP_DOWN;
                    pend_clr = 1'b1;
                end else if (!fifo_empty) begin
                    cmd_op_d = fifo_mem_q[rd_ptr_q];
                    pop      = 1'b1;
                end else begin
                    state_d     = S_SELECT;
                    cmd_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                cmd_valid_d = 1'b0;
            end
        endcase
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_req = btn_valid && legal_op && running_q;
    assign push     = push_req && (!fifo_full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cmd_valid_q    <= 1'b0;
            cmd_op_q       <= OP_NONE;
            need_gen_q     <= 1'b0;
            grav_pending_q <= 1'b0;
            grav_cnt_q     <= '0;
            sec_cnt_q      <= '0;
            sec_left_q     <= 7'd0;
            running_q      <= 1'b0;
            overflow_q     <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            state_q     <= state_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_op_q    <= cmd_op_d;
            need_gen_q  <= need_gen_d;
            if (start_game) begin
                grav_pending_q <= 1'b0;
                grav_cnt_q     <= '0;
                sec_cnt_q      <= '0;
                sec_left_q     <= 7'(COUNT_SEC);
                running_q      <= 1'b1;
                overflow_q     <= 1'b0;
                wr_ptr_q       <= '0;
                rd_ptr_q       <= '0;
                count_q        <= '0;
            end else begin
                if (running_q) begin
                    grav_cnt_q <= grav_wrap ? '0 : grav_cnt_q + GW'(1);
                    sec_cnt_q  <= sec_wrap ? '0 : sec_cnt_q + SW'(1);
                end
                // A fresh wrap wins over a same-cycle consume; pending never stacks.
                if (grav_wrap) begin
                    grav_pending_q <= 1'b1;
                end else if (pend_clr) begin
                    grav_pending_q <= 1'b0;
                end
                if (sec_wrap && (sec_left_q != 7'd0)) begin
                    sec_left_q <= sec_left_q - 7'd1;
                end
                if (stop_game) begin
                    running_q <= 1'b0;
                end
                if (push_req && fifo_full && !pop) begin
                    overflow_q <= 1'b1;
                end
                if (push) begin
                    wr_ptr_q <= ptr_inc(wr_ptr_q);
                end
                if (pop) begin
                    rd_ptr_q <= ptr_inc(rd_ptr_q);
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !start_game) begin
            fifo_mem_q[wr_ptr_q] <= btn_op;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_op    = cmd_op_q;
    assign sec_left  = sec_left_q;
    assign running   = running_q;
    assign overflow  = overflow_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_action_scheduler.sv
// Bench for action_scheduler: a cycle-level game model (queue + integer counters)
// checked every cycle, plus directed game scenarios with literal command order.
module tb_action_scheduler;

  localparam int QSIZE = 4;
  localparam int DOWN_TICK = 8;
  localparam int SEC_TICK = 10;
  localparam int COUNT_SEC = 3;

  localparam logic [7:0] INIT = 8'd1, GEN = 8'd2, LEFT = 8'd3, RIGHT = 8'd4;
  localparam logic [7:0] DOWN = 8'd5, DROP = 8'd6, HOLD = 8'd7, ROTATE = 8'd8;
  localparam logic [7:0] ROTATE_REV = 8'd9, END_OP = 8'd10, BAR = 8'd11;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic btn_valid = 1'b0;
  logic [7:0] btn_op = 8'd0;
  logic cmd_done = 1'b0;
  logic landed = 1'b0;
  logic game_over = 1'b0;
  logic cmd_valid;
  logic [7:0] cmd_op;
  logic [6:0] sec_left;
  logic running;
  logic overflow;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int obs_cyc = 0;
  int done_cyc = 0;
  int prev_done = 0;

  action_scheduler #(
    .QSIZE(QSIZE), .DOWN_TICK(DOWN_TICK), .SEC_TICK(SEC_TICK), .COUNT_SEC(COUNT_SEC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .btn_valid(btn_valid), .btn_op(btn_op),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_done(cmd_done), .landed(landed),
    .game_over(game_over), .sec_left(sec_left), .running(running), .overflow(overflow),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural game model ----------------
  bit m_valid = 0;
  logic [7:0] m_op = 8'd0;
  int m_sec = 0;
  bit m_running = 0, m_overflow = 0, m_pend = 0, m_need_gen = 0;
  bit m_decide = 0, m_session = 0;
  int m_gcnt = 0, m_scnt = 0;
  logic [7:0] exp_q[$];
  bit was_running, start_ok, grav_take, legal;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 0; m_op = 8'd0; m_sec = 0; m_running = 0; m_overflow = 0;
      m_pend = 0; m_need_gen = 0; m_decide = 0; m_session = 0;
      m_gcnt = 0; m_scnt = 0; exp_q.delete();
    end else begin
      was_running = m_running;
      start_ok = start && !m_session;
      grav_take = 0;
      legal = (btn_op >= LEFT) && (btn_op <= ROTATE_REV);
      if (m_decide) begin
        if (m_running && (game_over || m_sec == 0)) begin
          m_op = END_OP; m_valid = 1; m_decide = 0;
        end else if (m_need_gen) begin
          m_op = GEN; m_valid = 1; m_decide = 0; m_need_gen = 0;
        end else if (m_pend) begin
          m_op = DOWN; m_valid = 1; m_decide = 0; grav_take = 1;
        end else if (exp_q.size() != 0) begin
          m_op = exp_q.pop_front(); m_valid = 1; m_decide = 0;
        end
      end else if (m_valid && cmd_done) begin
        if (m_op == INIT) m_op = GEN;
        else if (m_op == END_OP) begin
          m_valid = 0; m_session = 0; m_running = 0;
        end else begin
          m_valid = 0; m_decide = 1; m_need_gen = landed;
        end
      end
      if (grav_take) m_pend = 0;
      if (was_running) begin
        if (m_gcnt == DOWN_TICK - 1) begin m_gcnt = 0; m_pend = 1; end
        else m_gcnt++;
        if (m_scnt == SEC_TICK - 1) begin
          m_scnt = 0;
          if (m_sec > 0) m_sec--;
        end else m_scnt++;
        if (btn_valid && legal) begin
          if (exp_q.size() < QSIZE) exp_q.push_back(btn_op);
          else m_overflow = 1;
        end
      end
      if (start_ok) begin
        m_session = 1; m_valid = 1; m_op = INIT; m_decide = 0; m_need_gen = 0;
        m_pend = 0; m_gcnt = 0; m_scnt = 0; m_sec = COUNT_SEC; m_running = 1;
        m_overflow = 0; exp_q.delete();
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("cycle_cmd_valid", cmd_valid, m_valid);
    if (m_valid) chk("cycle_cmd_op", cmd_op, m_op);
    chk("cycle_sec_left", sec_left, m_sec);
    chk("cycle_running", running, m_running);
    chk("cycle_overflow", overflow, m_overflow);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait (bounded) for a command, check its code, answer cmd_done after lat cycles.
  task automatic serve(input string name, input logic [7:0] exp_op, input int lat,
                       input logic land);
    int waited = 0;
    while (!cmd_valid && waited < 60) begin
      tick();
      waited++;
    end
    if (!cmd_valid) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: cmd_valid never rose, expected op %0d", name, exp_op);
    end else begin
      obs_cyc = cyc;
      chk(name, cmd_op, exp_op);
      repeat (lat - 1) tick();
      cmd_done = 1'b1;
      landed = land;
      done_cyc = cyc;
      tick();
      cmd_done = 1'b0;
      landed = 1'b0;
    end
  endtask

  logic [7:0] burst [5];

  // ---------------- scenarios ----------------
  initial begin
    burst[0] = LEFT; burst[1] = RIGHT; burst[2] = DROP; burst[3] = HOLD; burst[4] = ROTATE_REV;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_op", cmd_op, 0);
    chk("rst_sec_left", sec_left, 0);
    chk("rst_running", running, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_state_idle", dbg_state, 0);

    // Game A: start, INIT->GEN chain, two queued actions, gravity, timeout END
    pulse_start();
    chk("init_valid_t1", cmd_valid, 1);
    chk("init_op_t1", cmd_op, INIT);
    serve("init", INIT, 1, 1'b0);
    chk("gen_chain_op", cmd_op, GEN);
    chk("gen_chain_gap", cyc - done_cyc, 1);
    chk("gen_running", running, 1);
    chk("gen_sec_left", sec_left, 3);
    serve("gen", GEN, 1, 1'b0);
    chk("select_valid_low", cmd_valid, 0);
    chk("select_state", dbg_state, 2);
    btn_valid = 1'b1; btn_op = LEFT;
    tick();
    btn_op = ROTATE;
    tick();
    btn_valid = 1'b0;
    serve("q_left", LEFT, 2, 1'b0);
    prev_done = done_cyc;
    serve("q_rotate", ROTATE, 2, 1'b0);
    chk("rotate_gap", obs_cyc - prev_done, 2);
    serve("a_down1", DOWN, 2, 1'b0);
    serve("a_down2", DOWN, 2, 1'b0);
    serve("a_down3", DOWN, 2, 1'b0);
    serve("a_end_timeout", END_OP, 2, 1'b0);
    chk("a_over_running", running, 0);
    chk("a_over_state", dbg_state, 3);
    chk("a_over_sec", sec_left, 0);

    // Game B: overflow, push-with-pop, gravity priority, landed -> GEN
    pulse_start();
    btn_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      btn_op = burst[i];
      tick();
    end
    btn_valid = 1'b0;
    chk("b_overflow_set", overflow, 1);
    serve("b_init", INIT, 1, 1'b0);
    serve("b_gen", GEN, 1, 1'b0);
    btn_valid = 1'b1; btn_op = ROTATE;
    tick();
    btn_valid = 1'b0;
    serve("b_left", LEFT, 1, 1'b0);
    serve("b_down_first", DOWN, 1, 1'b1);
    serve("b_gen_landed", GEN, 1, 1'b0);
    serve("b_right", RIGHT, 1, 1'b0);
    serve("b_drop", DROP, 1, 1'b0);
    serve("b_down2", DOWN, 1, 1'b0);
    serve("b_hold", HOLD, 1, 1'b0);
    serve("b_rotate_full_pop", ROTATE, 1, 1'b0);
    serve("b_down3", DOWN, 1, 1'b0);
    serve("b_end", END_OP, 1, 1'b0);
    chk("b_overflow_sticky", overflow, 1);

    // Game C: blocked gravity, illegal code, start ignored, game_over END
    pulse_start();
    chk("c_overflow_cleared", overflow, 0);
    serve("c_init", INIT, 1, 1'b0);
    repeat (4) tick();
    btn_valid = 1'b1; btn_op = BAR;
    tick();
    btn_valid = 1'b0;
    pulse_start();
    chk("c_start_ignored", cmd_op, GEN);
    serve("c_gen_blocked", GEN, 13, 1'b0);
    serve("c_single_down", DOWN, 1, 1'b0);
    tick();
    chk("c_no_second_down_a", cmd_valid, 0);
    tick();
    chk("c_no_second_down_b", cmd_valid, 0);
    serve("c_down_next_wrap", DOWN, 1, 1'b0);
    game_over = 1'b1;
    serve("c_end_game_over", END_OP, 1, 1'b0);
    game_over = 1'b0;
    chk("c_over_running", running, 0);
    chk("c_bar_no_overflow", overflow, 0);
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    tick();
    chk("c_stray_done_ignored", dbg_state, 3);

    // Game D: asynchronous reset while a command is outstanding
    pulse_start();
    #2;
    reset = 1'b1;
    #1;
    chk("d_async_valid", cmd_valid, 0);
    chk("d_async_running", running, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("d_state_idle", dbg_state, 0);
    chk("d_sec_left", sec_left, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/action_scheduler.md
# action_scheduler

Sequences the Tetris game datapath: buffers player button actions in a QSIZE-deep FIFO, generates gravity DOWN and the per-second countdown, and issues exactly one command at a time to the datapath with a valid/done handshake. Sits between the debounced button decoder and the game-board state machine. Command codes are the `state_type` values of the `enum_type` package.

## Interface

- `QSIZE`, 16: action FIFO depth.
- `DOWN_TICK`, 25_000_000: cycles between gravity DOWN requests.
- `SEC_TICK`, 25_000_000: cycles per countdown second.
- `COUNT_SEC`, 60: game length in seconds.

- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse: begin a new game.
- `btn_valid`  in  1  one-cycle pulse: player action present.
- `btn_op`  in  8  action code; legal codes are LEFT, RIGHT, DOWN, DROP, HOLD, ROTATE, ROTATE_REV.
- `cmd_valid`  out  1  command outstanding to the datapath.
- `cmd_op`  out  8  command code (INIT, GEN, LEFT..ROTATE_REV, END).
- `cmd_done`  in  1  one-cycle pulse: datapath finished the current command.
- `landed`  in  1  sampled with `cmd_done`: the piece locked and a new piece is needed.
- `game_over`  in  1  level: board topped out.
- `sec_left`  out  7  remaining seconds.
- `running`  out  1  game in progress.
- `overflow`  out  1  sticky: an action was dropped on a full FIFO.

## Operation

- FSM states: IDLE, ISSUE, SELECT, OVER.
- IDLE: `start` flushes the FIFO, clears `overflow`, loads `sec_left`=COUNT_SEC, clears both tick counters and `grav_pending`, sets `running`, and issues INIT followed by GEN (ISSUE each).
- ISSUE: `cmd_valid`=1 with `cmd_op` stable until `cmd_done`. On `cmd_done` go to SELECT, except after INIT, which chains to GEN. If `landed`=1 with `cmd_done`, the next command is GEN.
- SELECT picks the next command (one cycle), priority: end-condition > GEN-needed > `grav_pending` (issues DOWN, clears pending) > FIFO head (pop) > stay in SELECT.
- End condition (`game_over`=1 or `sec_left`=0 while running) is checked only in SELECT. It issues END; on END `cmd_done`, clear `running` and go to OVER.
- OVER: holds; `start` restarts exactly as from IDLE.
- FIFO: push on `btn_valid` with a legal code while `running`. Illegal codes are dropped silently (no `overflow`).
- Full FIFO: push is dropped and `overflow` is set. A pop in the same cycle frees the slot first, so the push is accepted.
- FIFO pointers wrap modulo QSIZE; the count ranges 0..QSIZE.
- Gravity counter: counts 0..DOWN_TICK-1 while `running`; at wrap it sets `grav_pending`. A second wrap while pending does not accumulate.
- Second counter: counts 0..SEC_TICK-1 while `running`; at wrap it decrements `sec_left`, saturating at 0.
- `cmd_done` while `cmd_valid`=0 is ignored.

## Timing

- Reset values: `cmd_valid`=0, `cmd_op`=NONE(0), `sec_left`=0, `running`=0, `overflow`=0, FIFO empty, FSM in IDLE, counters 0, `grav_pending`=0.
- `start` at cycle t: `cmd_valid`=1 with INIT at t+1.
- `cmd_done` at cycle t: SELECT at t+1; the next `cmd_valid`=1 at t+2. A chained INIT→GEN asserts GEN at t+1.
- `btn_valid` at t is visible to SELECT from t+1.
- Async reset mid-command drops the command immediately: `cmd_valid`=0 in the same cycle.
- `start` is ignored outside IDLE/OVER.

## Test plan

Parameters for all scenarios: QSIZE=4, DOWN_TICK=8, SEC_TICK=10, COUNT_SEC=3.

- Reset then `start` → INIT at +1 cycle; `cmd_done` → GEN next cycle; `done` → SELECT; `running`=1, `sec_left`=3.
- Push LEFT, ROTATE, with `cmd_done` returned after 2 cycles → issued in order LEFT, ROTATE, each 2 cycles after the prior `done`; FIFO ends empty.
- Push 5 legal actions, no pops → 4 accepted, `overflow`=1. Push while full with a simultaneous pop → push accepted, count stays 4.
- Idle datapath, 8 cycles running with an empty FIFO → DOWN issued. A queued RIGHT plus a simultaneous `grav_pending` → DOWN issued before RIGHT. Two wraps while blocked → only one DOWN.
- DOWN `done` with `landed`=1 → next command GEN, even though the FIFO is non-empty.
- 30 running cycles → `sec_left`=0 → END issued; `done` → `running`=0 in OVER. `game_over`=1 earlier also yields END. `btn_op`=BAR → dropped, `overflow` stays 0.
